// File: rtl/gate_bist_pkg.sv
// rtl/gate_bist_pkg.sv - shared types, LFSR step and golden gate model for gate_bist
package gate_bist_pkg;

    typedef enum logic [2:0] {
        OP_AND, OP_OR, OP_XOR, OP_NAND, OP_NOR, OP_XNOR, OP_BUF, OP_NOT
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE, ST_APPLY, ST_SAMPLE, ST_DONE
    } state_e;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

    // Operands are carried at the maximum legal width; callers truncate.
    function automatic logic [15:0] gate_golden(input op_e op, input logic [15:0] a,
                                                input logic [15:0] b);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NAND: return ~(a & b);
            OP_NOR:  return ~(a | b);
            OP_XNOR: return ~(a ^ b);
            OP_BUF:  return a;
            default: return ~a;
        endcase
    endfunction

endpackage

// File: rtl/gate_bist_lfsr32.sv
// rtl/gate_bist_lfsr32.sv - 32-bit Galois LFSR with synchronous seed load
module lfsr32
    import gate_bist_pkg::*;
#(
    parameter logic [31:0] RESET_VAL = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        step,
    output logic [31:0] q
);

    logic [31:0] r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RESET_VAL;
        end else if (load) begin
            r_state <= seed;
        end else if (step) begin
            r_state <= lfsr_step(r_state);
        end
    end

    assign q = r_state;

endmodule

// File: rtl/gate_bist.sv
// rtl/gate_bist.sv - LFSR-driven self-test engine for one combinational gate function
module gate_bist
    import gate_bist_pkg::*;
#(
    parameter int          WIDTH       = 8,
    parameter int          NUM_VECTORS = 16,
    parameter logic [31:0] SEED        = 32'hACE1_0001
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [2:0]                           op,
    output logic [WIDTH-1:0]                     dut_a,
    output logic [WIDTH-1:0]                     dut_b,
    input  logic [WIDTH-1:0]                     dut_y,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 pass,
    output logic [$clog2(NUM_VECTORS+1)-1:0]     err_count,
    output logic [$clog2(NUM_VECTORS+1)-1:0]     first_fail
);

    localparam int          CW       = $clog2(NUM_VECTORS + 1);
    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [CW-1:0] LAST   = CW'(NUM_VECTORS - 1);

    state_e           r_state;
    op_e              r_op;
    logic [WIDTH-1:0] r_dut_a, r_dut_b;
    logic             r_busy, r_done, r_pass;
    logic [CW-1:0]    r_err, r_ff, r_idx;

    logic [31:0]      w_lfsr_q;
    logic [WIDTH-1:0] w_gold;
    logic             w_mis;
    logic [CW-1:0]    w_err_nxt;
    logic             w_load, w_step;

    assign w_load = (r_state == ST_IDLE) && start;
    assign w_step = (r_state == ST_SAMPLE);

    lfsr32 #(.RESET_VAL(SEED_EFF)) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (w_load),
        .seed (SEED_EFF),
        .step (w_step),
        .q    (w_lfsr_q)
    );

    assign w_gold    = WIDTH'(gate_golden(r_op, 16'(r_dut_a), 16'(r_dut_b)));
    // Case-inequality so an undriven or X result bit is reported as a failure.
    assign w_mis     = (dut_y !== w_gold);
    assign w_err_nxt = r_err + CW'(w_mis);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_op    <= OP_AND;
            r_dut_a <= '0;
            r_dut_b <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_ff    <= '1;
            r_idx   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_APPLY;
                        r_op    <= op_e'(op);
                        r_err   <= '0;
                        r_pass  <= 1'b0;
                        r_ff    <= '1;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_dut_a <= WIDTH'(SEED_EFF);
                        r_dut_b <= WIDTH'(SEED_EFF >> WIDTH);
                    end
                end
                ST_APPLY: r_state <= ST_SAMPLE;
                ST_SAMPLE: begin
                    r_err <= w_err_nxt;
                    if (w_mis && (r_ff == '1)) begin
                        r_ff <= r_idx;
                    end
                    if (r_idx == LAST) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_nxt == '0);
                    end else begin
                        r_state <= ST_APPLY;
                        r_idx   <= r_idx + CW'(1);
                        r_dut_a <= WIDTH'(lfsr_step(w_lfsr_q));
                        r_dut_b <= WIDTH'(lfsr_step(w_lfsr_q) >> WIDTH);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign dut_a      = r_dut_a;
    assign dut_b      = r_dut_b;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign err_count  = r_err;
    assign first_fail = r_ff;

endmodule

// File: tb/tb_gate_bist.sv
// tb/tb_gate_bist.sv - scoreboard bench for gate_bist
module tb_gate_bist;
    import gate_bist_pkg::*;

    localparam logic [31:0] SEED = 32'hACE1_0001;
    localparam int N = 16;

    typedef struct {
        logic p;
        int   err;
        int   ff;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, start1 = 1'b0;
    logic [2:0] op = 3'd0;
    logic [7:0] dut_a, dut_b, dut_y, y_ok;
    logic busy, done, pass;
    logic [4:0] err_count, first_fail;
    logic a1, b1, y1, busy1, done1, pass1, err1, ff1;

    int cur_op = 0;
    int mode = 0;
    int n_checks = 0;
    int n_fail = 0;
    logic [15:0] vq[$];
    res_t rq[$];

    always #5 clk = ~clk;

    assign y_ok  = 8'(gate_golden(op_e'(cur_op), 16'(dut_a), 16'(dut_b)));
    assign dut_y = (mode == 2) ? 8'bz : (mode == 1) ? (y_ok & 8'hF7) : y_ok;
    assign y1    = ~a1;

    gate_bist #(.WIDTH(8), .NUM_VECTORS(N), .SEED(SEED)) u_dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .dut_a(dut_a), .dut_b(dut_b), .dut_y(dut_y),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_fail(first_fail)
    );

    gate_bist #(.WIDTH(1), .NUM_VECTORS(1), .SEED(SEED)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .op(3'd7),
        .dut_a(a1), .dut_b(b1), .dut_y(y1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_fail(ff1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic run(input int opv, input int md, input int inj0, input int inj1,
                       input int inj2, input int abort_c);
        logic [31:0] l;
        logic [7:0]  g;
        logic        mis;
        int n_err, first, busy_cnt, done_cnt, done_at;
        res_t r, last_r;
        cur_op = opv;
        mode   = md;
        op     = 3'(opv);
        l = SEED;
        n_err = 0;
        first = 31;
        for (int i = 0; i < N; i++) begin
            vq.push_back(l[15:0]);
            g   = 8'(gate_golden(op_e'(opv), 16'(l[7:0]), 16'(l[15:8])));
            mis = (md == 2) ? 1'b1 : (md == 1) ? g[3] : 1'b0;
            if (mis) begin
                if (first == 31) first = i;
                n_err++;
            end
            l = (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
        end
        rq.push_back('{n_err == 0, n_err, first});
        last_r = '{1'b0, -1, -1};
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = -1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c <= 2 * N + 3; c++) begin
            if (c == abort_c) begin
                rst = 1'b1;
                #1;
                chk("abort_busy", 64'(busy), 64'd0);
                chk("abort_pass", 64'(pass), 64'd0);
                chk("abort_err", 64'(err_count), 64'd0);
                chk("abort_ff", 64'(first_fail), 64'h1F);
                chk("abort_ab", 64'({dut_b, dut_a}), 64'd0);
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    if (done) done_cnt++;
                end
                chk("abort_nodone", 64'(done_cnt), 64'd0);
                rst = 1'b0;
                vq.delete();
                rq.delete();
                return;
            end
            if (busy) busy_cnt++;
            if ((c % 2 == 0) && (c < 2 * N) && (vq.size() > 0))
                chk("vec_ab", 64'({dut_b, dut_a}), 64'(vq.pop_front()));
            if (done) begin
                done_cnt++;
                done_at = c;
                if (rq.size() == 0) begin
                    chk("sb_empty", 64'd0, 64'd1);
                end else begin
                    r = rq.pop_front();
                    last_r = r;
                    chk("pass", 64'(pass), 64'(r.p));
                    chk("err_count", 64'(err_count), 64'(r.err));
                    chk("first_fail", 64'(first_fail), 64'(r.ff));
                end
            end
            start = (c == inj0) || (c == inj1) || (c == inj2);
            @(negedge clk);
        end
        start = 1'b0;
        chk("busy_cycles", 64'(busy_cnt), 64'(2 * N));
        chk("done_count", 64'(done_cnt), 64'd1);
        chk("done_at", 64'(done_at), 64'(2 * N));
        chk("pass_hold", 64'(pass), 64'(last_r.p));
        chk("idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        int d1cnt, b1cnt;
        res_t r;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_pass", 64'(pass), 64'd0);
        chk("rst_err", 64'(err_count), 64'd0);
        chk("rst_ff", 64'(first_fail), 64'h1F);
        chk("rst_ab", 64'({dut_b, dut_a}), 64'd0);
        rst = 1'b0;

        run(0, 0, -1, -1, -1, -1);
        run(2, 1, -1, -1, -1, -1);
        run(4, 2, -1, -1, -1, -1);
        run(1, 0, 5, 31, 2 * N, -1);
        run(2, 1, -1, -1, -1, 9);
        run(3, 0, -1, -1, -1, -1);
        run(2, 1, -1, -1, -1, -1);

        vq.push_back(16'(SEED[1:0]));
        rq.push_back('{1'b1, 0, 1});
        d1cnt = 0;
        b1cnt = 0;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (c == 0) chk("w1_vec", 64'({b1, a1}), 64'(vq.pop_front()));
            if (busy1) b1cnt++;
            if (done1) begin
                d1cnt++;
                r = rq.pop_front();
                chk("w1_done_at", 64'(c), 64'd2);
                chk("w1_pass", 64'(pass1), 64'(r.p));
                chk("w1_err", 64'(err1), 64'(r.err));
                chk("w1_ff", 64'(ff1), 64'(r.ff));
            end
            @(negedge clk);
        end
        chk("w1_busy_cycles", 64'(b1cnt), 64'd2);
        chk("w1_done_count", 64'(d1cnt), 64'd1);
        chk("sb_drained", 64'(vq.size() + rq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
